// File: rtl/count_down.sv
// Four-digit BCD countdown timer with start/pause/load/clear pushbuttons,
// prescaled decrement, alarm at zero and active-low seven-segment outputs.
module count_down #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [17:0]     sw,
  input  logic [3:0]      KEY,
  output logic [3:0][6:0] hex,
  output logic            alarm,
  output logic            running
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0][3:0] num, num_d, num_dec, num_ld;
  logic [PW-1:0]   pre_q, pre_d;
  logic [2:0]      sync1_q, sync2_q, prev_q, press;
  logic            clr_p, ld_p, st_p, tick, dec_zero, borrow;
  logic            alarm_q, running_q;
  logic            unused;

  assign unused = ^{KEY[0], sw[17:16]};

  // Keys are active-low: a press is a 1->0 step after synchronization.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= KEY[3:1];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = prev_q & ~sync2_q;
  assign clr_p = press[2];
  assign ld_p  = press[0];
  assign st_p  = press[1];
  assign tick  = (state_q == RUN) && (pre_q == PRE_LAST);

  always_comb begin
    borrow = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      num_dec[i] = num[i];
      num_ld[i]  = (sw[4*i +: 4] > 4'd9) ? 4'd9 : sw[4*i +: 4];
      if (borrow) begin
        if (num[i] == 4'd0) begin
          num_dec[i] = 4'd9;
        end else begin
          num_dec[i] = num[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
    dec_zero = (num_dec == '0);
  end

  // Clear and load override everything, including a coincident tick.
  always_comb begin
    state_d = state_q;
    num_d   = num;
    pre_d   = pre_q;
    if (clr_p) begin
      num_d   = '0;
      pre_d   = '0;
      state_d = IDLE;
    end else if (ld_p) begin
      num_d   = num_ld;
      pre_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_p && (num != '0)) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            pre_d = '0;
            num_d = num_dec;
            if (dec_zero)  state_d = DONE;
            else if (st_p) state_d = PAUSE;
          end else begin
            pre_d = pre_q + PW'(1);
            if (st_p) state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (st_p) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num       <= '0;
      pre_q     <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num       <= num_d;
      pre_q     <= pre_d;
      alarm_q   <= (state_d == DONE);
      running_q <= (state_d == RUN);
    end
  end

  assign alarm   = alarm_q;
  assign running = running_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) hex[i] = seg7(num[i]);
  end

endmodule

// File: tb/tb_count_down.sv
// Bench for count_down: hand-derived vector table, corner sequences and
// random key traffic checked every cycle against a decimal-value model.
module tb_count_down;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [17:0]     sw;
  logic [3:0]      KEY;
  logic [3:0][6:0] hex;
  logic            alarm, running;

  count_down #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .sw(sw), .KEY(KEY),
    .hex(hex), .alarm(alarm), .running(running)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Model: plain decimal value, prescaler count and key sample history.
  int         m_val, m_pre, m_st;
  logic [3:1] k1, k2, k3;

  typedef struct {
    logic [2:0]  keys;   // bit0 load, bit1 start, bit2 clear
    logic [15:0] swv;
    int          wait_n;
    logic [15:0] num;
    logic        alarm;
    logic        running;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [17:0] s);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'(s[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_st = M_IDLE;
    k1 = '1; k2 = '1; k3 = '1;
  endtask

  task automatic model_step();
    logic [3:1] p;
    p = k3 & ~k2;
    if (p[3]) begin
      m_val = 0; m_pre = 0; m_st = M_IDLE;
    end else if (p[1]) begin
      m_val = clamp_val(sw); m_pre = 0; m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (p[2] && m_val != 0) m_st = M_RUN;
    end else if (m_st == M_PAUSE) begin
      if (p[2]) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        m_val = m_val - 1;
        if (m_val == 0) m_st = M_DONE;
        else if (p[2]) m_st = M_PAUSE;
      end else begin
        m_pre++;
        if (p[2]) m_st = M_PAUSE;
      end
    end
    k3 = k2; k2 = k1; k1 = KEY[3:1];
  endtask

  task automatic model_check();
    logic [15:0]     b;
    logic [3:0][6:0] h;
    b = to_bcd(m_val);
    for (int i = 0; i < 4; i++) h[i] = seg_tab[b[4*i +: 4]];
    chk("model_num", 32'(dut.num), 32'(b));
    chk("model_hex", 32'(hex), 32'(h));
    chk("model_alarm", 32'(alarm), 32'(m_st == M_DONE));
    chk("model_running", 32'(running), 32'(m_st == M_RUN));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic press(input logic [2:0] keys, input int hold);
    KEY = {~keys, 1'b1};
    repeat (hold) tick();
    KEY = 4'hF;
  endtask

  initial begin
    rst = 1'b1; sw = '0; KEY = 4'hF;
    model_reset();
    #12;
    chk("reset_num", 32'(dut.num), 32'h0);
    chk("reset_hex", 32'(hex), 32'({4{7'b1000000}}));
    chk("reset_alarm", 32'(alarm), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    rst = 1'b0;

    vecs[0]  = '{3'b010, 16'h0000, 1,  16'h0000, 1'b0, 1'b0}; // start at zero
    vecs[1]  = '{3'b001, 16'h0C25, 1,  16'h0925, 1'b0, 1'b0}; // load clamp
    vecs[2]  = '{3'b001, 16'h0100, 1,  16'h0100, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 16'h0100, 1,  16'h0100, 1'b0, 1'b1};
    vecs[4]  = '{3'b000, 16'h0100, 2,  16'h0099, 1'b0, 1'b1}; // borrow
    vecs[5]  = '{3'b000, 16'h0100, 2,  16'h0098, 1'b0, 1'b1};
    vecs[6]  = '{3'b101, 16'h0042, 1,  16'h0000, 1'b0, 1'b0}; // clear beats load
    vecs[7]  = '{3'b001, 16'h0002, 1,  16'h0002, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 16'h0002, 1,  16'h0002, 1'b0, 1'b1};
    vecs[9]  = '{3'b000, 16'h0002, 1,  16'h0002, 1'b0, 1'b1};
    vecs[10] = '{3'b010, 16'h0002, 1,  16'h0001, 1'b0, 1'b0}; // pause, pre=2
    vecs[11] = '{3'b000, 16'h0002, 18, 16'h0001, 1'b0, 1'b0};
    vecs[12] = '{3'b010, 16'h0002, 1,  16'h0001, 1'b0, 1'b1}; // resume
    vecs[13] = '{3'b000, 16'h0002, 0,  16'h0000, 1'b1, 1'b0}; // done
    vecs[14] = '{3'b010, 16'h0002, 1,  16'h0000, 1'b1, 1'b0}; // ignored
    vecs[15] = '{3'b001, 16'h0005, 1,  16'h0005, 1'b0, 1'b0};

    for (int v = 0; v < 16; v++) begin
      sw = {2'b00, vecs[v].swv};
      press(vecs[v].keys, 2);
      repeat (vecs[v].wait_n) tick();
      chk($sformatf("vec%0d_num", v), 32'(dut.num), 32'(vecs[v].num));
      chk($sformatf("vec%0d_alarm", v), 32'(alarm), 32'(vecs[v].alarm));
      chk($sformatf("vec%0d_running", v), 32'(running), 32'(vecs[v].running));
      if (v == 1) chk("vec1_hex0", 32'(hex[0]), 32'(7'b0010010));
    end

    // Held start key from IDLE with 0005: one start, runs to DONE.
    KEY = 4'b1011;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 5) chk("held_running", 32'(running), 32'h1);
    end
    KEY = 4'hF;
    chk("held_num", 32'(dut.num), 32'h0);
    chk("held_alarm", 32'(alarm), 32'h1);

    // Asynchronous reset while counting.
    sw = 18'h00123;
    press(3'b001, 2); tick();
    press(3'b010, 2); tick();
    repeat (6) tick();
    chk("pre_rst_num", 32'(dut.num), 32'h0122);
    #2 rst = 1'b1;
    #1;
    chk("arst_num", 32'(dut.num), 32'h0);
    chk("arst_hex", 32'(hex), 32'({4{7'b1000000}}));
    chk("arst_alarm", 32'(alarm), 32'h0);
    chk("arst_running", 32'(running), 32'h0);
    model_reset();
    #1 rst = 1'b0;

    // Random key traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 1; k < 4; k++) begin
        if (KEY[k]) begin
          if ($urandom_range(0, (k == 3) ? 59 : 9) == 0) KEY[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          KEY[k] = 1'b1;
        end
      end
      if ($urandom_range(0, 15) == 0)
        sw = ($urandom_range(0, 3) == 0) ? 18'($urandom) : {10'h000, 8'($urandom)};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
